id_branch_resolve: RTL and testbench

- ID-stage branch/jump resolution unit.
- Consumes the ID forwarding selects (forward1/forward2) to build branch operands, compares them, and computes the target.
- Drives PC redirect and IF/ID flush.
- Owns a stall FSM that holds ID while a branch operand is still in flight (ALU result in ID/EX, load in ID/EX or EX/MEM).

---
 rtl/id_branch_resolve_if.sv | 49 ++++
 rtl/id_branch_resolve.sv | 130 +++++++++++++
 tb/tb_id_branch_resolve.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/id_branch_resolve_if.sv
// Bundle of ID-stage branch resolution inputs (decode, operands, hazard info)
// and the redirect/stall outputs.
interface id_branch_resolve_if #(
  parameter int unsigned XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm;
  logic [4:0]      if_id_rs1;
  logic [4:0]      if_id_rs2;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  logic [1:0]      forward1;
  logic [1:0]      forward2;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] mem_wb_wdata;
  logic            id_ex_RegWrite;
  logic            id_ex_MemRead;
  logic [4:0]      id_ex_rd;
  logic            ex_mem_MemRead;
  logic [4:0]      ex_mem_rd;
  logic            id_flush;

  logic            stall_id;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if_id;
  logic            target_misalign;

  modport slave (
    input  id_valid, id_pc, is_branch, is_jal, is_jalr, funct3, imm,
           if_id_rs1, if_id_rs2, rf_rs1_data, rf_rs2_data, forward1, forward2,
           ex_mem_alu_result, mem_wb_wdata, id_ex_RegWrite, id_ex_MemRead,
           id_ex_rd, ex_mem_MemRead, ex_mem_rd, id_flush,
    output stall_id, redirect_valid, redirect_pc, flush_if_id, target_misalign
  );

  modport master (
    output id_valid, id_pc, is_branch, is_jal, is_jalr, funct3, imm,
           if_id_rs1, if_id_rs2, rf_rs1_data, rf_rs2_data, forward1, forward2,
           ex_mem_alu_result, mem_wb_wdata, id_ex_RegWrite, id_ex_MemRead,
           id_ex_rd, ex_mem_MemRead, ex_mem_rd, id_flush,
    input  stall_id, redirect_valid, redirect_pc, flush_if_id, target_misalign
  );
endinterface

// File: rtl/id_branch_resolve.sv
// ID-stage branch/jump resolution with operand-hazard stall FSM.
// Optional macro BRANCH_STATS_EN adds saturating branch/taken/stall counters.
module id_branch_resolve #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STALL_CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  id_branch_resolve_if.slave     bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_taken,
  output logic [31:0]            stat_stall_cycles
`endif
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic                   uses_rs1, uses_rs2, is_ctrl, active;
  logic                   hit_id_ex, hit_ex_mem;
  logic [STALL_CNT_W-1:0] hz_n;
  logic [XLEN-1:0]        op_a, op_b, target;
  logic                   cond, taken, stall, resolve;

  // A source register collides with rd only if it is actually read and not x0
  function automatic logic rs_hit(input logic [4:0] rd, input logic u1, input logic u2,
                                  input logic [4:0] rs1, input logic [4:0] rs2);
    return (u1 && (rs1 != 5'd0) && (rs1 == rd)) ||
           (u2 && (rs2 != 5'd0) && (rs2 == rd));
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] exm, input logic [XLEN-1:0] mwb);
    case (sel)
      2'b10:   return exm;
      2'b01:   return mwb;
      default: return rf;
    endcase
  endfunction

  always_comb begin
    uses_rs1   = bus.is_branch | bus.is_jalr;
    uses_rs2   = bus.is_branch;
    is_ctrl    = bus.is_branch | bus.is_jal | bus.is_jalr;
    active     = rst_n & bus.id_valid & is_ctrl & ~bus.id_flush;
    hit_id_ex  = rs_hit(bus.id_ex_rd, uses_rs1, uses_rs2, bus.if_id_rs1, bus.if_id_rs2);
    hit_ex_mem = rs_hit(bus.ex_mem_rd, uses_rs1, uses_rs2, bus.if_id_rs1, bus.if_id_rs2);

    // Load in ID/EX needs two cycles; ALU result in ID/EX or load in EX/MEM needs one
    if (bus.id_ex_MemRead && hit_id_ex)       hz_n = STALL_CNT_W'(2);
    else if (bus.id_ex_RegWrite && hit_id_ex) hz_n = STALL_CNT_W'(1);
    else if (bus.ex_mem_MemRead && hit_ex_mem) hz_n = STALL_CNT_W'(1);
    else                                      hz_n = '0;
  end

  always_comb begin
    op_a = fwd_mux(bus.forward1, bus.rf_rs1_data, bus.ex_mem_alu_result, bus.mem_wb_wdata);
    op_b = fwd_mux(bus.forward2, bus.rf_rs2_data, bus.ex_mem_alu_result, bus.mem_wb_wdata);

    case (bus.funct3)
      3'b000:  cond = (op_a == op_b);
      3'b001:  cond = (op_a != op_b);
      3'b100:  cond = ($signed(op_a) <  $signed(op_b));
      3'b101:  cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  cond = (op_a <  op_b);
      3'b111:  cond = (op_a >= op_b);
      default: cond = 1'b0;
    endcase

    if (bus.is_jalr) target = (op_a + bus.imm) & ~XLEN'(1);
    else             target = bus.id_pc + bus.imm;

    taken = bus.is_jal | bus.is_jalr | (bus.is_branch & cond);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall; WAIT holds for cnt cycles after the first stall cycle in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (bus.id_flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_q == ST_WAIT) begin
      stall = 1'b1;
      cnt_d = cnt_q - STALL_CNT_W'(1);
      if (cnt_q <= STALL_CNT_W'(1)) state_d = ST_RUN;
    end else if (active && (hz_n != '0)) begin
      stall = 1'b1;
      cnt_d = hz_n - STALL_CNT_W'(1);
      if (cnt_d != '0) state_d = ST_WAIT;
    end
  end

  assign resolve             = active & ~stall;
  assign bus.stall_id        = stall & rst_n;
  assign bus.target_misalign = resolve & taken & target[1];
  assign bus.redirect_valid  = resolve & taken & ~target[1];
  assign bus.flush_if_id     = resolve & taken & ~target[1];
  assign bus.redirect_pc     = rst_n ? target : '0;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches     <= '0;
      stat_taken        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (resolve && (stat_branches != '1))            stat_branches     <= stat_branches + 32'd1;
      if (bus.redirect_valid && (stat_taken != '1))    stat_taken        <= stat_taken + 32'd1;
      if (bus.stall_id && (stat_stall_cycles != '1))   stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_branch_resolve.sv
// Directed self-checking bench for id_branch_resolve; outputs are sampled 1ns
// after the falling edge where inputs are applied.
module tb_id_branch_resolve;
  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  id_branch_resolve_if #(.XLEN(32)) bus ();

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_stall_cycles;
`endif

  id_branch_resolve #(.XLEN(32), .STALL_CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_taken        (stat_taken),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_pc = 0; bus.is_branch = 0; bus.is_jal = 0; bus.is_jalr = 0;
    bus.funct3 = 0; bus.imm = 0; bus.if_id_rs1 = 0; bus.if_id_rs2 = 0;
    bus.rf_rs1_data = 0; bus.rf_rs2_data = 0; bus.forward1 = 0; bus.forward2 = 0;
    bus.ex_mem_alu_result = 0; bus.mem_wb_wdata = 0; bus.id_ex_RegWrite = 0;
    bus.id_ex_MemRead = 0; bus.id_ex_rd = 0; bus.ex_mem_MemRead = 0; bus.ex_mem_rd = 0;
    bus.id_flush = 0;
  endtask

  task automatic branch(input logic [31:0] pc, input logic [31:0] im, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2);
    idle();
    bus.id_valid = 1; bus.is_branch = 1; bus.id_pc = pc; bus.imm = im; bus.funct3 = f3;
    bus.if_id_rs1 = rs1; bus.if_id_rs2 = rs2; bus.rf_rs1_data = d1; bus.rf_rs2_data = d2;
  endtask

  task automatic jalr(input logic [31:0] d1, input logic [31:0] im);
    idle();
    bus.id_valid = 1; bus.is_jalr = 1; bus.id_pc = 32'h400; bus.imm = im;
    bus.if_id_rs1 = 5'd3; bus.rf_rs1_data = d1;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic rv,
                            input logic fl, input logic mis);
    check({tag, ".stall"}, 32'(bus.stall_id), 32'(st));
    check({tag, ".rv"},    32'(bus.redirect_valid), 32'(rv));
    check({tag, ".flush"}, 32'(bus.flush_if_id), 32'(fl));
    check({tag, ".mis"},   32'(bus.target_misalign), 32'(mis));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle();
    #2;
    expect_out("reset", 0, 0, 0, 0);
    check("reset.rpc", bus.redirect_pc, 32'h0);
    @(negedge clk); rst_n = 1;

    // BEQ taken, same cycle
    @(negedge clk); branch(32'h100, 32'h20, 3'b000, 5'd1, 5'd2, 32'd5, 32'd5); #1;
    expect_out("beq", 0, 1, 1, 0);
    check("beq.rpc", bus.redirect_pc, 32'h120);

    // BLT with -1 forwarded from EX/MEM vs 1, then BLTU on same operands
    @(negedge clk); branch(32'h100, 32'h40, 3'b100, 5'd1, 5'd2, 32'd0, 32'd1);
    bus.forward1 = 2'b10; bus.ex_mem_alu_result = 32'hFFFF_FFFF; #1;
    expect_out("blt", 0, 1, 1, 0);
    check("blt.rpc", bus.redirect_pc, 32'h140);
    bus.funct3 = 3'b110; #1;
    expect_out("bltu", 0, 0, 0, 0);

    // funct3 010 is never taken
    bus.funct3 = 3'b010; bus.rf_rs1_data = 32'd1; bus.forward1 = 2'b00; #1;
    expect_out("f3_010", 0, 0, 0, 0);

    // BNE behind a load in ID/EX: two stall cycles, then resolves from MEM/WB
    @(negedge clk); branch(32'h300, 32'h10, 3'b001, 5'd7, 5'd8, 32'h66, 32'h66);
    bus.id_ex_MemRead = 1; bus.id_ex_RegWrite = 1; bus.id_ex_rd = 5'd7; #1;
    expect_out("bne.s1", 1, 0, 0, 0);
    @(negedge clk);
    bus.id_ex_MemRead = 0; bus.id_ex_RegWrite = 0; bus.id_ex_rd = 0;
    bus.ex_mem_MemRead = 1; bus.ex_mem_rd = 5'd7; #1;
    expect_out("bne.s2", 1, 0, 0, 0);
    @(negedge clk);
    bus.ex_mem_MemRead = 0; bus.ex_mem_rd = 0;
    bus.forward1 = 2'b01; bus.mem_wb_wdata = 32'h55; #1;
    expect_out("bne.res", 0, 1, 1, 0);
    check("bne.rpc", bus.redirect_pc, 32'h310);

    // ALU producer on rs2 in ID/EX: single stall cycle
    @(negedge clk); branch(32'h500, 32'h8, 3'b000, 5'd4, 5'd9, 32'd3, 32'd0);
    bus.id_ex_RegWrite = 1; bus.id_ex_rd = 5'd9; #1;
    expect_out("n1.s1", 1, 0, 0, 0);
    @(negedge clk);
    bus.id_ex_RegWrite = 0; bus.id_ex_rd = 0;
    bus.forward2 = 2'b10; bus.ex_mem_alu_result = 32'd3; #1;
    expect_out("n1.res", 0, 1, 1, 0);
    check("n1.rpc", bus.redirect_pc, 32'h508);

    // JALR target forms
    @(negedge clk); jalr(32'h1003, 32'h0); #1;
    check("jalr0.rpc", bus.redirect_pc, 32'h1002);
    expect_out("jalr0", 0, 0, 0, 1);
    jalr(32'h1003, 32'h2); #1;
    check("jalr2.rpc", bus.redirect_pc, 32'h1004);
    expect_out("jalr2", 0, 1, 1, 0);
    jalr(32'h1001, 32'h1); #1;
    check("jalr1.rpc", bus.redirect_pc, 32'h1002);
    jalr(32'h2000, 32'h2); #1;
    check("jalrm.rpc", bus.redirect_pc, 32'h2002);
    expect_out("jalrm", 0, 0, 0, 1);

    // JAL with wrap-around
    idle(); bus.id_valid = 1; bus.is_jal = 1; bus.id_pc = 32'hFFFF_FFF0; bus.imm = 32'h20; #1;
    expect_out("jal", 0, 1, 1, 0);
    check("jal.rpc", bus.redirect_pc, 32'h10);

    // id_flush while in WAIT
    @(negedge clk); branch(32'h300, 32'h10, 3'b001, 5'd7, 5'd0, 32'h1, 32'h0);
    bus.id_ex_MemRead = 1; bus.id_ex_rd = 5'd7; #1;
    expect_out("fl.s1", 1, 0, 0, 0);
    @(negedge clk); bus.id_flush = 1; #1;
    expect_out("fl.kill", 0, 0, 0, 0);
    @(negedge clk); branch(32'h100, 32'h20, 3'b000, 5'd1, 5'd2, 32'd5, 32'd5); #1;
    expect_out("fl.after", 0, 1, 1, 0);

    // Reset asserted mid-WAIT with inputs still active
    @(negedge clk); branch(32'h300, 32'h10, 3'b001, 5'd7, 5'd0, 32'h1, 32'h0);
    bus.id_ex_MemRead = 1; bus.id_ex_rd = 5'd7;
    @(negedge clk); #1;
    expect_out("rw.wait", 1, 0, 0, 0);
    #1 rst_n = 0; #1;
    expect_out("rw.rst", 0, 0, 0, 0);
    check("rw.rpc", bus.redirect_pc, 32'h0);
    @(negedge clk); rst_n = 1; idle(); #1;
    expect_out("rw.idle", 0, 0, 0, 0);

    // x0 never hazards
    @(negedge clk); branch(32'h700, 32'h4, 3'b000, 5'd0, 5'd0, 32'd0, 32'd0);
    bus.id_ex_MemRead = 1; bus.id_ex_RegWrite = 1; bus.id_ex_rd = 5'd0; #1;
    expect_out("x0", 0, 1, 1, 0);
    check("x0.rpc", bus.redirect_pc, 32'h704);

    @(negedge clk); idle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
